// File: rtl/riscv_pkg.sv
// Shared types for the riscv memory arbiter: FSM state, transaction owner
// and memory access size encodings.
package riscv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10
    } arb_owner_t;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

endpackage

// File: rtl/riscv_arb_sel.sv
// Combinational requester select: data has priority unless fetch has been
// refused long enough to hit the starvation limit.
module riscv_arb_sel (
    input  logic if_req,
    input  logic d_req,
    input  logic starve_hit,
    input  logic can_grant,
    output logic if_gnt,
    output logic d_gnt
);

    assign if_gnt = can_grant & if_req & (~d_req | starve_hit);
    assign d_gnt  = can_grant & d_req  & ~(if_req & starve_hit);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares a single-port fixed-latency memory between instruction fetch and
// load/store, with one transaction outstanding at a time.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_size_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [1:0]  m_size_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    output logic        stall_o
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(MAX_STARVE + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_STARVE);

    arb_state_t       state;
    arb_owner_t       owner;
    logic             owner_we;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;

    logic resp;
    logic can_grant;
    logic starve_hit;

    // The response cycle doubles as the next grant slot, giving back-to-back
    // accesses every MEM_LAT cycles. Grants are gated while reset is held.
    assign resp       = (state == BUSY) && (lat_cnt == '0);
    assign can_grant  = rst && ((state == IDLE) || resp);
    assign starve_hit = (starve_cnt == STV_MAX);

    riscv_arb_sel u_sel (
        .if_req     (if_req_i),
        .d_req      (d_req_i),
        .starve_hit (starve_hit),
        .can_grant  (can_grant),
        .if_gnt     (if_gnt_o),
        .d_gnt      (d_gnt_o)
    );

    always_comb begin
        m_req_o   = if_gnt_o | d_gnt_o;
        m_we_o    = d_gnt_o & d_we_i;
        m_size_o  = 2'b00;
        m_addr_o  = '0;
        m_wdata_o = '0;
        if (d_gnt_o) begin
            m_size_o  = d_size_i;
            m_addr_o  = d_addr_i;
            m_wdata_o = d_we_i ? d_wdata_i : '0;
        end else if (if_gnt_o) begin
            m_size_o  = WORD;
            m_addr_o  = if_addr_i;
        end
    end

    assign if_rvalid_o = resp && (owner == FETCH);
    assign d_rvalid_o  = resp && (owner == DATA);
    assign if_rdata_o  = if_rvalid_o ? m_rdata_i : '0;
    assign d_rdata_o   = (d_rvalid_o && !owner_we) ? m_rdata_i : '0;

    assign stall_o = rst & ((if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= NONE;
            owner_we   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if (m_req_o) begin
                state    <= BUSY;
                lat_cnt  <= LAT_LOAD;
                owner    <= d_gnt_o ? DATA : FETCH;
                owner_we <= d_gnt_o & d_we_i;
            end else if (state == BUSY) begin
                if (lat_cnt == '0) begin
                    state    <= IDLE;
                    owner    <= NONE;
                    owner_we <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end

            // A withdrawn fetch request forfeits its accumulated priority.
            if (if_req_i && !if_gnt_o) begin
                if (!starve_hit)
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule
